// File: rtl/color_fsm_pkg.sv
// Shared types and path logic for driving the colour-state FSM:
// state/command encodings, the FSM's expected output per state, and the next-hop routing rule.
package color_fsm_pkg;

    typedef enum logic [1:0] {
        BLUE     = 2'd0,
        RED      = 2'd1,
        HSV_IDLE = 2'd2
    } color_state_t;

    localparam logic [1:0] CMD_0          = 2'd0;
    localparam logic [1:0] CMD_1          = 2'd1;
    localparam logic [1:0] CMD_2          = 2'd2;
    localparam logic [1:0] CMD_NOP        = 2'd3;
    localparam logic [1:0] TARGET_INVALID = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RECOVER
    } drv_state_t;

    typedef struct packed {
        logic [1:0]   cmd;
        color_state_t nxt;
    } hop_t;

    // Red and HSV both present 2 on the FSM output; only Blue is distinguishable.
    function automatic logic [1:0] expected_out(input color_state_t s);
        logic [1:0] o;
        case (s)
            BLUE:    o = 2'd1;
            default: o = 2'd2;
        endcase
        return o;
    endfunction

    function automatic hop_t next_hop(input color_state_t cur, input color_state_t tgt);
        hop_t h;
        h.cmd = CMD_NOP;
        h.nxt = cur;
        if (tgt != cur) begin
            case (cur)
                BLUE: begin
                    h.cmd = CMD_1;
                    h.nxt = RED;
                end
                RED: begin
                    if (tgt == BLUE) begin
                        h.cmd = CMD_1;
                        h.nxt = BLUE;
                    end else if (tgt == HSV_IDLE) begin
                        h.cmd = CMD_2;
                        h.nxt = HSV_IDLE;
                    end
                end
                HSV_IDLE: begin
                    h.cmd = CMD_0;
                    h.nxt = RED;
                end
                default: begin
                    h.cmd = CMD_NOP;
                    h.nxt = cur;
                end
            endcase
        end
        return h;
    endfunction

endpackage

// File: rtl/color_fsm_cmd_driver_if.sv
// Request, FSM-link and status signals of the colour-FSM command driver.
interface color_fsm_cmd_driver_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic [1:0]       req_target;
    logic             req_ready;
    logic [1:0]       cmd;
    logic [1:0]       fsm_out;
    logic             done;
    logic             err;
    logic             err_clr;
    logic [1:0]       cur_state;
    logic [CNT_W-1:0] hop_count;

    modport master (
        input  req_valid, req_target, fsm_out, err_clr,
        output req_ready, cmd, done, err, cur_state, hop_count
    );

    modport slave (
        output req_valid, req_target, fsm_out, err_clr,
        input  req_ready, cmd, done, err, cur_state, hop_count
    );
endinterface

// File: rtl/color_fsm_cmd_driver.sv
// Steers the colour FSM to a requested state with the shortest command sequence,
// tracking a shadow state and verifying each hop against the FSM's output.
module color_fsm_cmd_driver
    import color_fsm_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    color_fsm_cmd_driver_if.master bus
);

    localparam int              SW          = $clog2(SETTLE + 1) + 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE);

    drv_state_t       state_reg, state_next;
    logic [1:0]       cmd_reg, cmd_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    color_state_t     cur_state_reg, cur_state_next;
    color_state_t     exp_state_reg, exp_state_next;
    logic [1:0]       target_reg, target_next;
    logic [CNT_W-1:0] hop_count_reg, hop_count_next;
    logic [SW-1:0]    settle_reg, settle_next;

    logic             err_set;
    logic             accept;
    color_state_t     hop_from;
    logic [1:0]       hop_to;
    hop_t             hop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cmd_reg       <= CMD_NOP;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cur_state_reg <= RED;
            exp_state_reg <= RED;
            target_reg    <= 2'd1;
            hop_count_reg <= '0;
            settle_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_reg       <= cmd_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            cur_state_reg <= cur_state_next;
            exp_state_reg <= exp_state_next;
            target_reg    <= target_next;
            hop_count_reg <= hop_count_next;
            settle_reg    <= settle_next;
        end
    end

    // One shared route lookup: from the confirmed state when issuing from IDLE/ISSUE,
    // from the just-confirmed hop when chaining out of WAIT.
    always_comb begin
        hop_from = (state_reg == WAIT) ? exp_state_reg : cur_state_reg;
        hop_to   = (state_reg == IDLE) ? bus.req_target : target_reg;
        hop      = next_hop(hop_from, color_state_t'(hop_to));
    end

    assign accept = (state_reg == IDLE) && !done_reg && bus.req_valid;

    always_comb begin
        state_next     = state_reg;
        cmd_next       = CMD_NOP;
        done_next      = 1'b0;
        err_set        = 1'b0;
        cur_state_next = cur_state_reg;
        exp_state_next = exp_state_reg;
        target_next    = target_reg;
        hop_count_next = hop_count_reg;
        settle_next    = settle_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    target_next = bus.req_target;
                    if (bus.req_target == TARGET_INVALID) begin
                        err_set   = 1'b1;
                        done_next = 1'b1;
                    end else if (bus.req_target == cur_state_reg) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ISSUE;
                        cmd_next   = hop.cmd;
                    end
                end
            end

            ISSUE: begin
                hop_count_next = hop_count_reg + 1'b1;
                exp_state_next = hop.nxt;
                settle_next    = SW'(1);
                state_next     = WAIT;
            end

            WAIT: begin
                if (settle_reg == SETTLE_LAST) begin
                    if (bus.fsm_out == expected_out(exp_state_reg)) begin
                        cur_state_next = exp_state_reg;
                        if (exp_state_reg == target_reg) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            cmd_next   = hop.cmd;
                            state_next = ISSUE;
                        end
                    end else begin
                        err_set     = 1'b1;
                        cmd_next    = CMD_0;
                        settle_next = '0;
                        state_next  = RECOVER;
                    end
                end else begin
                    settle_next = settle_reg + SW'(1);
                end
            end

            RECOVER: begin
                // settle count 0 is the cycle the recovery command is on the wire
                if (settle_reg == '0) begin
                    hop_count_next = hop_count_reg + 1'b1;
                end
                if (settle_reg == SETTLE_LAST) begin
                    cur_state_next = (bus.fsm_out == 2'd1) ? BLUE : RED;
                    done_next      = 1'b1;
                    state_next     = IDLE;
                end else begin
                    settle_next = settle_reg + SW'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        err_next = err_set | (err_reg & ~bus.err_clr);
    end

    assign bus.req_ready = (state_reg == IDLE) && !done_reg;
    assign bus.cmd       = cmd_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.cur_state = cur_state_reg;
    assign bus.hop_count = hop_count_reg;

endmodule

// File: tb/tb_color_fsm_cmd_driver.sv
// Bench for the colour-FSM command driver: a colour FSM responder, a per-request timeline
// model compared every cycle, and directed requests with literal expectations.
module tb_color_fsm_cmd_driver;
    import color_fsm_pkg::*;

    localparam int SETTLE = 1;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    color_fsm_cmd_driver_if #(.CNT_W(CNT_W)) bus ();

    color_fsm_cmd_driver #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    function automatic void chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Colour FSM transition table and its output.
    function automatic int fsm_step(input int s, input int c);
        int n;
        n = s;
        if (c != 3) begin
            case (s)
                0: if (c == 1) n = 1;
                1: begin
                    if (c == 1) n = 0;
                    else if (c == 2) n = 2;
                end
                2: if (c == 0) n = 1;
                default: n = s;
            endcase
        end
        return n;
    endfunction

    function automatic int fsm_outv(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    // Responder: the colour FSM itself, plus an override used to fake a bad hop.
    logic [1:0] resp_q;
    logic       force_en  = 1'b0;
    logic [1:0] force_val = 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) resp_q <= 2'd1;
        else     resp_q <= 2'(fsm_step(int'(resp_q), int'(bus.cmd)));
    end

    assign bus.fsm_out = force_en ? force_val : 2'(fsm_outv(int'(resp_q)));

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model: on acceptance, lay out the whole per-cycle timeline of the request.
    typedef struct {
        int cmd;
        int done;
        int cur;
        int hops;
        int err_set;
    } step_t;

    step_t plan[$];
    int m_cmd = 3, m_done = 0, m_ready = 1, m_err = 0, m_cur = 1, m_hops = 0;

    task automatic build_plan(input int tgt);
        int s, hc, n, rec;
        int pc[2];
        int ps[2];
        bit found, bad;
        s = m_cur; hc = m_hops; n = 0; found = 0;
        if (tgt == 3) begin
            plan.push_back('{3, 1, s, hc, 1});
            return;
        end
        if (tgt != s) begin
            for (int c = 0; c < 3; c++)
                if (!found && fsm_step(s, c) == tgt) begin
                    pc[0] = c; ps[0] = tgt; n = 1; found = 1;
                end
            for (int c1 = 0; c1 < 3; c1++)
                for (int c2 = 0; c2 < 3; c2++) begin
                    int mid;
                    mid = fsm_step(s, c1);
                    if (!found && mid != s && mid != tgt && fsm_step(mid, c2) == tgt) begin
                        pc[0] = c1; ps[0] = mid; pc[1] = c2; ps[1] = tgt; n = 2; found = 1;
                    end
                end
        end
        for (int k = 0; k < n; k++) begin
            plan.push_back('{pc[k], 0, s, hc, 0});
            hc++;
            for (int w = 0; w < SETTLE; w++) plan.push_back('{3, 0, s, hc, 0});
            bad = force_en && (fsm_outv(ps[k]) != int'(force_val));
            if (bad) begin
                rec = (force_val == 2'd1) ? 0 : 1;
                plan.push_back('{0, 0, s, hc, 1});
                hc++;
                for (int w = 0; w < SETTLE; w++) plan.push_back('{3, 0, s, hc, 0});
                plan.push_back('{3, 1, rec, hc, 0});
                return;
            end
            s = ps[k];
        end
        plan.push_back('{3, 1, s, hc, 0});
    endtask

    initial forever begin
        step_t e;
        int set;
        @(posedge clk or posedge rst);
        if (rst) begin
            plan.delete();
            m_cmd = 3; m_done = 0; m_ready = 1; m_err = 0; m_cur = 1; m_hops = 0;
        end else begin
            set = 0;
            if (plan.size() == 0 && m_ready == 1 && bus.req_valid == 1'b1)
                build_plan(int'(bus.req_target));
            if (plan.size() > 0) begin
                e = plan.pop_front();
                m_cmd = e.cmd; m_done = e.done; m_cur = e.cur; m_ready = 0;
                m_hops = e.hops % (1 << CNT_W);
                set = e.err_set;
            end else begin
                m_cmd = 3; m_done = 0; m_ready = 1;
            end
            m_err = (set != 0) ? 1 : (bus.err_clr ? 0 : m_err);
        end
    end

    // Compare every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("cmd",       int'(bus.cmd),       m_cmd);
        chk("done",      int'(bus.done),      m_done);
        chk("req_ready", int'(bus.req_ready), m_ready);
        chk("err",       int'(bus.err),       m_err);
        chk("cur_state", int'(bus.cur_state), m_cur);
        chk("hop_count", int'(bus.hop_count), m_hops);
    end

    task automatic run_req(input int tgt, output int lat_cmd, output int lat_done,
                           output int c0, output int c1, output int ncmd);
        int t0, waited;
        lat_cmd = -1; lat_done = -1; c0 = -1; c1 = -1; ncmd = 0; waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        bus.req_valid  = 1'b1;
        bus.req_target = 2'(tgt);
        t0 = cyc;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.cmd != 2'd3) begin
                if (ncmd == 0) begin
                    lat_cmd = cyc - t0;
                    c0 = int'(bus.cmd);
                end else if (ncmd == 1) begin
                    c1 = int'(bus.cmd);
                end
                ncmd++;
            end
            if (bus.done) begin
                lat_done = cyc - t0;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat_done < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done, want done within 60 cycles (target %0d)", tgt);
        end
        $display("req target=%0d cmds=%0d first_cmd=%0d second_cmd=%0d done_latency=%0d cur_state=%0d hops=%0d err=%0d",
                 tgt, ncmd, c0, c1, lat_done, bus.cur_state, bus.hop_count, bus.err);
    endtask

    initial begin
        int lc, ld, c0, c1, nc;
        bus.req_valid  = 1'b0;
        bus.req_target = 2'd0;
        bus.err_clr    = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_cmd",       int'(bus.cmd),       3);
        chk("rst_cur_state", int'(bus.cur_state), 1);
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_done",      int'(bus.done),      0);
        chk("rst_err",       int'(bus.err),       0);
        chk("rst_hop_count", int'(bus.hop_count), 0);

        // Red -> Blue, one hop
        run_req(0, lc, ld, c0, c1, nc);
        chk("r2b_lat_cmd",  lc, 1);
        chk("r2b_cmd",      c0, 1);
        chk("r2b_ncmd",     nc, 1);
        chk("r2b_lat_done", ld, 2 + SETTLE);
        chk("r2b_cur",      int'(bus.cur_state), 0);
        chk("r2b_hops",     int'(bus.hop_count), 1);
        chk("r2b_fsm_out",  int'(bus.fsm_out),   1);

        // Blue -> HSV, two hops via Red
        run_req(2, lc, ld, c0, c1, nc);
        chk("b2h_cmd0",     c0, 1);
        chk("b2h_cmd1",     c1, 2);
        chk("b2h_ncmd",     nc, 2);
        chk("b2h_lat_done", ld, 1 + 2 * (1 + SETTLE));
        chk("b2h_cur",      int'(bus.cur_state), 2);
        chk("b2h_hops",     int'(bus.hop_count), 3);
        chk("b2h_fsm_out",  int'(bus.fsm_out),   2);

        // Already there: zero hops
        run_req(2, lc, ld, c0, c1, nc);
        chk("same_lat_done", ld, 1);
        chk("same_ncmd",     nc, 0);
        chk("same_hops",     int'(bus.hop_count), 3);

        // Invalid target
        run_req(3, lc, ld, c0, c1, nc);
        chk("inv_lat_done", ld, 1);
        chk("inv_ncmd",     nc, 0);
        chk("inv_err",      int'(bus.err), 1);
        chk("inv_cur",      int'(bus.cur_state), 2);
        @(posedge clk); #1;
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        chk("errclr_err", int'(bus.err), 0);

        // Set and clear in the same cycle: set wins
        bus.err_clr = 1'b1;
        run_req(3, lc, ld, c0, c1, nc);
        chk("setwins_err", int'(bus.err), 1);
        bus.err_clr = 1'b0;
        @(posedge clk); #1;
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        chk("errclr2_err", int'(bus.err), 0);

        // Reset during WAIT of HSV -> Blue (two hops)
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_target = 2'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rstmid_issue_cmd", int'(bus.cmd), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstmid_cmd",  int'(bus.cmd),       3);
        chk("rstmid_cur",  int'(bus.cur_state), 1);
        chk("rstmid_done", int'(bus.done),      0);
        chk("rstmid_hops", int'(bus.hop_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rstmid_no_done", int'(bus.done), 0);
        end
        $display("reset applied mid-request, request dropped");

        run_req(0, lc, ld, c0, c1, nc);
        chk("post_rst_lat_done", ld, 2 + SETTLE);
        chk("post_rst_cur",      int'(bus.cur_state), 0);
        chk("post_rst_hops",     int'(bus.hop_count), 1);

        // Back to Red, then a Red -> HSV hop whose feedback is faked as Blue
        run_req(1, lc, ld, c0, c1, nc);
        chk("b2r_cur", int'(bus.cur_state), 1);
        force_en  = 1'b1;
        force_val = 2'd1;
        run_req(2, lc, ld, c0, c1, nc);
        force_en  = 1'b0;
        chk("bad_cmd0",     c0, 2);
        chk("bad_cmd1",     c1, 0);
        chk("bad_ncmd",     nc, 2);
        chk("bad_lat_done", ld, 2 + 2 * SETTLE + 1);
        chk("bad_err",      int'(bus.err),       1);
        chk("bad_cur",      int'(bus.cur_state), 0);
        chk("bad_hops",     int'(bus.hop_count), 4);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
